cacheline_adaptor: RTL and testbench

- Memory-side responder for the L1 cacheline request port.
- Accepts one 256-bit line read or write from the cache arbiter.
- Moves the line to or from physical memory as a 4-beat, 64-bit burst, then returns a single-cycle `pmem_resp_cla` with the assembled line.
- Sits between the arbiter's `pmem_*_cla` outputs and the physical memory model/controller.

---
 rtl/cacheline_adaptor_pkg.sv | 18 +
 rtl/cacheline_adaptor_if.sv | 50 +++++
 rtl/cacheline_adaptor.sv | 123 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the L1 cacheline memory-side adaptor.
// The line is always LINE_W bits; beat count/width defaults must multiply to it.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } cla_state_t;

  localparam int LINE_W         = 256;
  localparam int OFFSET_W       = 5;
  localparam int ADDR_W         = 32;
  localparam int BEATS_DEFAULT  = 4;
  localparam int BEAT_W_DEFAULT = 64;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundles the arbiter-facing line port and the memory-facing burst port.
// slave is the adaptor's view; master is the view of the arbiter plus memory model.
interface cacheline_adaptor_if;
  import cache_types_pkg::*;

  logic                      pmem_read_cla;
  logic                      pmem_write_cla;
  logic [ADDR_W-1:0]         pmem_address_cla;
  logic [LINE_W-1:0]         pmem_wdata_256_cla;
  logic                      pmem_resp_cla;
  logic [LINE_W-1:0]         pmem_rdata_256_cla;

  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_address;
  logic [BEAT_W_DEFAULT-1:0] mem_wdata_64;
  logic                      mem_resp;
  logic [BEAT_W_DEFAULT-1:0] mem_rdata_64;

  modport slave (
    input  pmem_read_cla,
    input  pmem_write_cla,
    input  pmem_address_cla,
    input  pmem_wdata_256_cla,
    output pmem_resp_cla,
    output pmem_rdata_256_cla,
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata_64,
    input  mem_resp,
    input  mem_rdata_64
  );

  modport master (
    output pmem_read_cla,
    output pmem_write_cla,
    output pmem_address_cla,
    output pmem_wdata_256_cla,
    input  pmem_resp_cla,
    input  pmem_rdata_256_cla,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata_64,
    output mem_resp,
    output mem_rdata_64
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line request into a 4-beat 64-bit memory burst and
// answers the arbiter with a single-cycle response carrying the assembled line.
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int BEATS  = BEATS_DEFAULT,
  parameter int BEAT_W = BEAT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam int CNT_W = $clog2(BEATS);
  typedef logic [CNT_W-1:0] cnt_t;

  cla_state_t        state;
  cla_state_t        state_next;
  cnt_t              cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] line_buf [BEATS];
  logic [BEAT_W-1:0] wr_buf   [BEATS];
  logic [LINE_W-1:0] rdata_line;
  logic              last_beat;
  logic              read_burst;
  logic              write_burst;
  logic              resp_pulse;
  logic              unused_offset;

  assign last_beat     = (cnt == cnt_t'(BEATS - 1));
  assign unused_offset = ^bus.pmem_address_cla[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      for (int i = 0; i < BEATS; i++) begin
        line_buf[i] <= '0;
        wr_buf[i]   <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.pmem_read_cla || bus.pmem_write_cla) begin
            addr_q <= {bus.pmem_address_cla[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            cnt    <= '0;
          end
          // A simultaneous read and write is served as a read, so the write line is not captured.
          if (!bus.pmem_read_cla && bus.pmem_write_cla) begin
            for (int i = 0; i < BEATS; i++) begin
              wr_buf[i] <= bus.pmem_wdata_256_cla[i*BEAT_W +: BEAT_W];
            end
          end
        end
        READ: begin
          if (bus.mem_resp) begin
            line_buf[cnt] <= bus.mem_rdata_64;
            cnt           <= cnt + cnt_t'(1);
          end
        end
        WRITE: begin
          if (bus.mem_resp) begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    read_burst  = 1'b0;
    write_burst = 1'b0;
    resp_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pmem_read_cla) begin
          state_next = READ;
        end else if (bus.pmem_write_cla) begin
          state_next = WRITE;
        end
      end
      READ: begin
        read_burst = 1'b1;
        if (bus.mem_resp && last_beat) begin
          state_next = RESP;
        end
      end
      WRITE: begin
        write_burst = 1'b1;
        if (bus.mem_resp && last_beat) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_pulse = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_line = '0;
    for (int i = 0; i < BEATS; i++) begin
      rdata_line[i*BEAT_W +: BEAT_W] = line_buf[i];
    end
  end

  assign bus.mem_read           = read_burst;
  assign bus.mem_write          = write_burst;
  assign bus.mem_address        = addr_q;
  assign bus.mem_wdata_64       = wr_buf[cnt];
  assign bus.pmem_resp_cla      = resp_pulse;
  assign bus.pmem_rdata_256_cla = rdata_line;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes, gaps, back-to-back,
// mid-burst reset and the read-wins case, each with hand-computed expectations.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  localparam logic [255:0] READ_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  cacheline_adaptor_if bus();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    bus.pmem_read_cla = 1'b0; bus.pmem_write_cla = 1'b0;
    bus.pmem_address_cla = '0; bus.pmem_wdata_256_cla = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata_64 = '0;
    #1 rst = 1'b0;
    #2;
    vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_resp: got %b want 0", bus.pmem_resp_cla); end
    vectors++; if (bus.pmem_rdata_256_cla !== 256'h0) begin miscompares++; $display("[TB] FAIL rst_rdata: got %h want 0", bus.pmem_rdata_256_cla); end
    vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_read: got %b want 0", bus.mem_read); end
    vectors++; if (bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_write: got %b want 0", bus.mem_write); end
    vectors++; if (bus.mem_address !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_address: got %h want 0", bus.mem_address); end
    vectors++; if (bus.mem_wdata_64 !== 64'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata_64); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_release_idle: got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
  endtask

  task automatic test_read();
    logic [63:0] beat [4];
    beat[0] = 64'h1111_1111_1111_1111;
    beat[1] = 64'h2222_2222_2222_2222;
    beat[2] = 64'h3333_3333_3333_3333;
    beat[3] = 64'h4444_4444_4444_4444;
    $display("[TB] test_read");
    bus.pmem_address_cla = 32'h0000_1234;
    bus.pmem_read_cla    = 1'b1;
    #1;
    vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_c0_mem_read: got %b want 0", bus.mem_read); end
    tick();
    vectors++; if (bus.mem_address !== 32'h0000_1220) begin miscompares++; $display("[TB] FAIL rd_mem_address: got %h want 00001220", bus.mem_address); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_mem_read c%0d: got %b want 1", k + 1, bus.mem_read); end
      vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_resp c%0d: got %b want 0", k + 1, bus.pmem_resp_cla); end
      bus.mem_resp     = 1'b1;
      bus.mem_rdata_64 = beat[k];
      tick();
    end
    bus.mem_resp     = 1'b0;
    bus.mem_rdata_64 = '0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_resp_c5: got %b want 1", bus.pmem_resp_cla); end
    vectors++; if (bus.pmem_rdata_256_cla !== READ_LINE) begin miscompares++; $display("[TB] FAIL rd_line: got %h want %h", bus.pmem_rdata_256_cla, READ_LINE); end
    vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_resp_mem_read: got %b want 0", bus.mem_read); end
    tick();
    bus.pmem_read_cla = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_resp_width: got %b want 0", bus.pmem_resp_cla); end
  endtask

  task automatic test_write();
    logic [63:0] d [4];
    logic        pat [5];
    int          idx;
    d[0] = 64'h0000_0000_C0DE_0000;
    d[1] = 64'h1111_2222_3333_4444;
    d[2] = 64'hFEDC_BA98_7654_3210;
    d[3] = 64'h8000_0000_0000_0001;
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    idx  = 0;
    $display("[TB] test_write");
    bus.pmem_address_cla   = 32'h8000_0040;
    bus.pmem_wdata_256_cla = {d[3], d[2], d[1], d[0]};
    bus.pmem_write_cla     = 1'b1;
    bus.mem_rdata_64       = 64'hBADB_ADBA_DBAD_BADB;
    tick();
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_levels c%0d: got rd=%b wr=%b want 0 1", k + 1, bus.mem_read, bus.mem_write); end
      vectors++; if (bus.mem_address !== 32'h8000_0040) begin miscompares++; $display("[TB] FAIL wr_mem_address c%0d: got %h want 80000040", k + 1, bus.mem_address); end
      vectors++; if (bus.mem_wdata_64 !== d[idx]) begin miscompares++; $display("[TB] FAIL wr_beat c%0d: got %h want %h", k + 1, bus.mem_wdata_64, d[idx]); end
      vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_early_resp c%0d: got %b want 0", k + 1, bus.pmem_resp_cla); end
      bus.mem_resp = pat[k];
      tick();
      if (pat[k]) idx++;
    end
    bus.mem_resp     = 1'b0;
    bus.mem_rdata_64 = '0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_resp_c6: got %b want 1", bus.pmem_resp_cla); end
    vectors++; if (bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_resp_mem_write: got %b want 0", bus.mem_write); end
    vectors++; if (bus.pmem_rdata_256_cla !== READ_LINE) begin miscompares++; $display("[TB] FAIL wr_line_held: got %h want %h", bus.pmem_rdata_256_cla, READ_LINE); end
    tick();
    bus.pmem_write_cla = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_resp_width: got %b want 0", bus.pmem_resp_cla); end
  endtask

  task automatic test_gapped_read();
    logic [63:0]  e [4];
    logic         pat [8];
    logic [255:0] exp_line;
    int           idx;
    e[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    e[1] = 64'h0F0F_0F0F_0F0F_0F0F;
    e[2] = 64'hCAFE_F00D_1234_5678;
    e[3] = 64'h0000_0000_FFFF_FFFF;
    exp_line = {64'h0000_0000_FFFF_FFFF, 64'hCAFE_F00D_1234_5678,
                64'h0F0F_0F0F_0F0F_0F0F, 64'hA5A5_A5A5_A5A5_A5A5};
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idx = 0;
    $display("[TB] test_gapped_read");
    bus.pmem_address_cla = 32'hABCD_EF1F;
    bus.pmem_read_cla    = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'hABCD_EF00) begin miscompares++; $display("[TB] FAIL gap_steady c%0d: got rd=%b addr=%h want 1 abcdef00", c, bus.mem_read, bus.mem_address); end
      vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_early_resp c%0d: got %b want 0", c, bus.pmem_resp_cla); end
      bus.mem_resp     = pat[c-1];
      bus.mem_rdata_64 = pat[c-1] ? e[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
      if (pat[c-1]) idx++;
      tick();
    end
    bus.mem_resp     = 1'b0;
    bus.mem_rdata_64 = '0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_resp_c9: got %b want 1", bus.pmem_resp_cla); end
    vectors++; if (bus.pmem_rdata_256_cla !== exp_line) begin miscompares++; $display("[TB] FAIL gap_line: got %h want %h", bus.pmem_rdata_256_cla, exp_line); end
    tick();
    bus.pmem_read_cla = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] g [4];
    g[0] = 64'h0101_0101_0101_0101;
    g[1] = 64'h0202_0202_0202_0202;
    g[2] = 64'h0303_0303_0303_0303;
    g[3] = 64'h0404_0404_0404_0404;
    $display("[TB] test_back_to_back");
    bus.pmem_address_cla = 32'h0000_0100;
    bus.pmem_read_cla    = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp     = 1'b1;
      bus.mem_rdata_64 = 64'h5A5A_0000_0000_0000 | 64'(k);
      tick();
    end
    bus.mem_resp = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_read_resp: got %b want 1", bus.pmem_resp_cla); end
    tick();
    bus.pmem_read_cla      = 1'b0;
    bus.pmem_write_cla     = 1'b1;
    bus.pmem_address_cla   = 32'h0000_0040;
    bus.pmem_wdata_256_cla = {g[3], g[2], g[1], g[0]};
    vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_c6_resp: got %b want 0", bus.pmem_resp_cla); end
    tick();
    vectors++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_c7_levels: got rd=%b wr=%b want 0 1", bus.mem_read, bus.mem_write); end
    vectors++; if (bus.mem_address !== 32'h0000_0040) begin miscompares++; $display("[TB] FAIL b2b_c7_address: got %h want 00000040", bus.mem_address); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.mem_wdata_64 !== g[k]) begin miscompares++; $display("[TB] FAIL b2b_beat%0d: got %h want %h", k, bus.mem_wdata_64, g[k]); end
      vectors++; if (bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_spurious_resp c%0d: got %b want 0", k + 7, bus.pmem_resp_cla); end
      bus.mem_resp = 1'b1;
      tick();
    end
    bus.mem_resp = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_write_resp: got %b want 1", bus.pmem_resp_cla); end
    tick();
    bus.pmem_write_cla = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b0 || bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_after: got resp=%b wr=%b want 0 0", bus.pmem_resp_cla, bus.mem_write); end
  endtask

  task automatic test_midburst_reset();
    logic [255:0] exp_line;
    exp_line = {64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999,
                64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777};
    $display("[TB] test_midburst_reset");
    bus.pmem_address_cla = 32'h0000_2000;
    bus.pmem_read_cla    = 1'b1;
    tick();
    bus.mem_resp = 1'b1; bus.mem_rdata_64 = 64'h5555_5555_5555_5555;
    tick();
    bus.mem_rdata_64 = 64'h6666_6666_6666_6666;
    tick();
    bus.mem_rdata_64 = 64'hEEEE_EEEE_EEEE_EEEE;
    #2 rst = 1'b0;
    bus.pmem_read_cla = 1'b0;
    #1;
    vectors++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL mrst_async_drop: got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
    vectors++; if (bus.pmem_rdata_256_cla !== 256'h0 || bus.pmem_resp_cla !== 1'b0) begin miscompares++; $display("[TB] FAIL mrst_line: got resp=%b line=%h want 0 0", bus.pmem_resp_cla, bus.pmem_rdata_256_cla); end
    vectors++; if (bus.mem_address !== 32'h0 || bus.mem_wdata_64 !== 64'h0) begin miscompares++; $display("[TB] FAIL mrst_addr_wdata: got %h %h want 0 0", bus.mem_address, bus.mem_wdata_64); end
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (bus.mem_read !== 1'b0 || bus.pmem_resp_cla !== 1'b0 || bus.pmem_rdata_256_cla !== 256'h0) begin miscompares++; $display("[TB] FAIL mrst_idle_ignores_beat: got rd=%b resp=%b line=%h want 0 0 0", bus.mem_read, bus.pmem_resp_cla, bus.pmem_rdata_256_cla); end
    bus.mem_resp = 1'b0;
    bus.pmem_address_cla = 32'h0000_3000;
    bus.pmem_read_cla    = 1'b1;
    tick();
    vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0000_3000) begin miscompares++; $display("[TB] FAIL mrst_restart: got rd=%b addr=%h want 1 00003000", bus.mem_read, bus.mem_address); end
    bus.mem_resp = 1'b1;
    bus.mem_rdata_64 = 64'h7777_7777_7777_7777; tick();
    bus.mem_rdata_64 = 64'h8888_8888_8888_8888; tick();
    bus.mem_rdata_64 = 64'h9999_9999_9999_9999; tick();
    bus.mem_rdata_64 = 64'hAAAA_AAAA_AAAA_AAAA; tick();
    bus.mem_resp = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1) begin miscompares++; $display("[TB] FAIL mrst_resp: got %b want 1", bus.pmem_resp_cla); end
    vectors++; if (bus.pmem_rdata_256_cla !== exp_line) begin miscompares++; $display("[TB] FAIL mrst_line_order: got %h want %h", bus.pmem_rdata_256_cla, exp_line); end
    tick();
    bus.pmem_read_cla = 1'b0;
  endtask

  task automatic test_illegal_both();
    logic [255:0] exp_line;
    exp_line = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
    $display("[TB] test_illegal_both");
    bus.pmem_address_cla   = 32'h0000_0567;
    bus.pmem_wdata_256_cla = '1;
    bus.pmem_read_cla      = 1'b1;
    bus.pmem_write_cla     = 1'b1;
    tick();
    vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0000_0560) begin miscompares++; $display("[TB] FAIL both_read_start: got rd=%b addr=%h want 1 00000560", bus.mem_read, bus.mem_address); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL both_mem_write c%0d: got %b want 0", k + 1, bus.mem_write); end
      bus.mem_resp     = 1'b1;
      bus.mem_rdata_64 = 64'(k + 1);
      tick();
    end
    bus.mem_resp = 1'b0;
    vectors++; if (bus.pmem_resp_cla !== 1'b1 || bus.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL both_resp: got resp=%b wr=%b want 1 0", bus.pmem_resp_cla, bus.mem_write); end
    vectors++; if (bus.pmem_rdata_256_cla !== exp_line) begin miscompares++; $display("[TB] FAIL both_line: got %h want %h", bus.pmem_rdata_256_cla, exp_line); end
    tick();
    bus.pmem_read_cla  = 1'b0;
    bus.pmem_write_cla = 1'b0;
    tick();
    vectors++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL both_after: got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_read();
    test_write();
    test_gapped_read();
    test_back_to_back();
    test_midburst_reset();
    test_illegal_both();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
